// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time, data first.
// A fetch or load/store answers 3 cycles after it is granted at minimum; m_addr_ok/m_data_ok wait states stretch that.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,

  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_data_ok,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_data_ok,

  output logic                  stallreq_inst,
  output logic                  stallreq_data,

  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state;
  logic   owner_inst;
  logic   owner_data;
  logic   cancel;
  logic   resp_inst;
  logic   resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_inst <= 1'b0;
      owner_data <= 1'b0;
      cancel     <= 1'b0;
      resp_inst  <= 1'b0;
      resp_data  <= 1'b0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_addr     <= '0;
      m_wstrb    <= '0;
      m_wdata    <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            owner_data <= 1'b1;
            owner_inst <= 1'b0;
            cancel     <= 1'b0;
            m_req      <= 1'b1;
            m_wr       <= data_wr;
            m_size     <= data_size;
            m_addr     <= data_addr;
            m_wstrb    <= data_wstrb;
            m_wdata    <= data_wdata;
            state      <= ADDR;
          end else if (inst_req) begin
            owner_data <= 1'b0;
            owner_inst <= 1'b1;
            cancel     <= 1'b0;
            m_req      <= 1'b1;
            m_wr       <= 1'b0;
            m_size     <= 2'd2;
            m_addr     <= inst_addr;
            m_wstrb    <= '0;
            m_wdata    <= '0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // A flushed fetch still runs to completion on the port; only its answer is dropped.
          if (owner_inst && flush) cancel <= 1'b1;
          if (m_addr_ok) begin
            m_req <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (owner_inst && flush) cancel <= 1'b1;
          if (m_data_ok) begin
            if (owner_inst) inst_rdata <= m_rdata;
            else            data_rdata <= m_rdata;
            resp_inst <= owner_inst & ~cancel & ~flush;
            resp_data <= owner_data;
            state     <= RESP;
          end
        end
        RESP: begin
          resp_inst  <= 1'b0;
          resp_data  <= 1'b0;
          owner_inst <= 1'b0;
          owner_data <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the response cycle itself must still kill the fetch answer.
  assign inst_data_ok  = resp_inst & ~flush;
  assign data_data_ok  = resp_data;

  assign stallreq_inst = inst_req & ~inst_data_ok;
  assign stallreq_data = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model, directed scenarios with literal pins, then random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        stallreq_inst;
  logic        stallreq_data;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: one transaction granted at cycle g, address phase lasts a+1 cycles, data phase d+1 cycles, then one answer cycle.
  bit          busy = 0, own_d = 0, cancel = 0;
  int          g = 0, a = 0, d = 0;
  logic        l_wr;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata, cap;
  logic [3:0]  l_wstrb;
  bit          pulse_i_prev = 0, pulse_d_prev = 0;

  bit          rand_mode = 0;
  int          force_a = -1, force_d = -1, flush_at = -1;
  bit          force_rd_en = 0;
  logic [31:0] force_rd = '0;

  int          n_iok, n_dok, n_mreq, n_stall_d, last_iok_cyc, last_dok_cyc;
  logic [31:0] last_irdata, last_drdata, inst_addr_seen;
  bit          seen_mreq, seen_inst_addr;
  logic        first_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_iok = 0; n_dok = 0; n_mreq = 0; n_stall_d = 0;
    last_iok_cyc = -1; last_dok_cyc = -1;
    last_irdata = '0; last_drdata = '0; inst_addr_seen = '0;
    seen_mreq = 0; seen_inst_addr = 0; first_wr = 1'bx;
  endtask

  task automatic req_update();
    if (rand_mode) begin
      if (pulse_d_prev || !data_req) begin
        data_req = ($urandom_range(0, 2) != 0);
        data_wr = 1'($urandom_range(0, 1));
        data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom;
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
      end
      if (pulse_i_prev || !inst_req) begin
        inst_req = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      flush = ($urandom_range(0, 7) == 0);
    end else begin
      if (pulse_d_prev) data_req = 1'b0;
      if (pulse_i_prev) inst_req = 1'b0;
      flush = (cyc == flush_at);
    end
  endtask

  task automatic cycle();
    bit e_mreq, e_iok, e_dok, in_resp;
    int rel;
    e_mreq = 0; e_iok = 0; e_dok = 0; in_resp = 0;
    m_addr_ok = 1'($urandom_range(0, 1));
    m_data_ok = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    if (busy) begin
      rel = cyc - g;
      if (rel <= 1 + a) begin
        e_mreq = 1;
        m_addr_ok = (rel == 1 + a);
      end else if (rel <= 2 + a + d) begin
        m_data_ok = (rel == 2 + a + d);
        if (m_data_ok) begin
          if (force_rd_en) m_rdata = force_rd;
          cap = m_rdata;
        end
      end else begin
        in_resp = 1;
        if (own_d) e_dok = 1;
        else e_iok = !cancel && !flush;
      end
      if (!own_d && flush && !in_resp) cancel = 1;
    end else if (data_req || inst_req) begin
      busy = 1; g = cyc; cancel = 0; own_d = data_req;
      a = (force_a >= 0) ? force_a : int'($urandom_range(0, 3));
      d = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
      if (data_req) begin
        l_wr = data_wr; l_size = data_size; l_addr = data_addr; l_wstrb = data_wstrb; l_wdata = data_wdata;
      end else begin
        l_wr = 1'b0; l_size = 2'd2; l_addr = inst_addr; l_wstrb = 4'd0; l_wdata = '0;
      end
    end

    @(negedge clk);
    chk("m_req", m_req, e_mreq);
    if (e_mreq) begin
      chk("m_wr", m_wr, l_wr);
      chk("m_size", m_size, l_size);
      chk("m_addr", m_addr, l_addr);
      chk("m_wstrb", m_wstrb, l_wstrb);
      if (own_d) chk("m_wdata", m_wdata, l_wdata);
    end
    chk("inst_data_ok", inst_data_ok, e_iok);
    chk("data_data_ok", data_data_ok, e_dok);
    if (e_iok) chk("inst_rdata", inst_rdata, cap);
    if (e_dok) chk("data_rdata", data_rdata, cap);
    chk("stallreq_inst", stallreq_inst, inst_req & ~e_iok);
    chk("stallreq_data", stallreq_data, data_req & ~e_dok);

    if (inst_data_ok) begin n_iok++; last_iok_cyc = cyc; last_irdata = inst_rdata; end
    if (data_data_ok) begin n_dok++; last_dok_cyc = cyc; last_drdata = data_rdata; end
    if (stallreq_data) n_stall_d++;
    if (m_req) begin
      n_mreq++;
      if (!seen_mreq) begin seen_mreq = 1; first_wr = m_wr; end
      if (!m_wr && !seen_inst_addr) begin seen_inst_addr = 1; inst_addr_seen = m_addr; end
    end

    if (in_resp) busy = 0;
    pulse_i_prev = e_iok;
    pulse_d_prev = e_dok;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      req_update();
      cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; data_req = 1'b0; inst_req = 1'b0; flush = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0; busy = 0; cancel = 0; pulse_i_prev = 0; pulse_d_prev = 0;
    // Late port handshakes right after reset must be ignored.
    m_data_ok = 1'b1; m_addr_ok = 1'b1; m_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_stallreq_inst", stallreq_inst, 0);
    chk("rst_stallreq_data", stallreq_data, 0);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int t;
    clr_mon();
    do_reset();
    run(2);

    // Single load, address accepted immediately, data one cycle late.
    clr_mon();
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_1000; data_wstrb = 4'hF; data_wdata = '0;
    force_a = 0; force_d = 1; force_rd_en = 1; force_rd = 32'hDEAD_BEEF;
    t = cyc;
    run(8);
    chk("load_latency", last_dok_cyc - t, 4);
    chk("load_rdata", last_drdata, 32'hDEAD_BEEF);
    chk("load_stall_cycles", n_stall_d, 4);
    chk("load_pulses", n_dok, 1);

    // Simultaneous store and fetch: store must own the port first.
    clr_mon();
    force_a = -1; force_d = -1; force_rd_en = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h0000_2000; data_wstrb = 4'b0010; data_wdata = 32'hCAFE_F00D;
    run(30);
    chk("both_first_is_store", first_wr, 1);
    chk("both_inst_addr", inst_addr_seen, 32'hBFC0_0000);
    chk("both_inst_pulses", n_iok, 1);
    chk("both_data_pulses", n_dok, 1);

    // Flush while the fetch waits for data: answer dropped, refetch served.
    clr_mon();
    force_a = 0; force_d = 2; force_rd_en = 1; force_rd = 32'h1234_5678;
    inst_req = 1; inst_addr = 32'h0000_0100;
    t = cyc; flush_at = t + 3;
    run(16);
    flush_at = -1;
    chk("flush_inst_pulses", n_iok, 1);
    chk("flush_refetch_latency", last_iok_cyc - t, 11);
    chk("flush_refetch_rdata", last_irdata, 32'h1234_5678);

    // Flush during a store's address phase has no effect on it.
    clr_mon();
    force_a = 2; force_d = 0; force_rd_en = 0;
    data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h0000_3000; data_wstrb = 4'b0011; data_wdata = 32'h0000_BEEF;
    t = cyc; flush_at = t + 2;
    run(10);
    flush_at = -1;
    chk("store_flush_pulses", n_dok, 1);
    chk("store_flush_latency", last_dok_cyc - t, 5);

    // Address backpressure: request held for six cycles.
    clr_mon();
    force_a = 5; force_d = 0;
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h0000_4003; data_wstrb = 4'b1000;
    t = cyc;
    run(12);
    chk("bp_mreq_cycles", n_mreq, 6);
    chk("bp_latency", last_dok_cyc - t, 8);

    // Reset while waiting for read data.
    clr_mon();
    force_a = 0; force_d = 4;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_5000;
    run(3);
    do_reset();
    run(4);
    chk("rst_mid_pulses", n_dok, 0);

    // Random traffic with random wait states, spurious handshakes and flushes.
    force_a = -1; force_d = -1; force_rd_en = 0;
    rand_mode = 1;
    run(4000);
    rand_mode = 0;
    data_req = 0; inst_req = 0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one sram-like memory port between the instruction-fetch requester (IF) and the data requester (MEM stage loads/stores). It serialises accesses with one outstanding transaction at a time, routes read data back to the owner, raises per-requester stall requests for the pipeline controller, and discards instruction responses cancelled by an exception flush. It sits between the IF/MEM stages and the top-level memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write strobe width is DATA_W/8

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  exception flush from CP0/ctrl; cancels the in-flight instruction access
- inst_req  in  1  IF read request; held with inst_addr stable until inst_data_ok
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word; valid while inst_data_ok
- inst_data_ok  out  1  one-cycle response pulse to IF
- data_req  in  1  MEM request; held with its fields stable until data_data_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  ADDR_W  byte address
- data_wstrb  in  DATA_W/8  byte enables, same encoding as the MEM byte select
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  raw load word (MEM stage does extension)
- data_data_ok  out  1  one-cycle response pulse to MEM
- stallreq_inst  out  1  inst_req & ~inst_data_ok
- stallreq_data  out  1  data_req & ~data_data_ok
- m_req, m_wr, m_size[1:0], m_addr[ADDR_W], m_wstrb, m_wdata  out  shared-port request
- m_addr_ok  in  1  port accepted the address phase
- m_data_ok  in  1  port returned read data / write completion
- m_rdata  in  DATA_W  port read data

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if data_req, grant data; else if inst_req, grant inst; else stay. On grant, latch the requester's fields into the request register, record owner, clear cancel, go to ADDR. Inst requests use m_wr=0, m_size=2, m_wstrb=0.
- ADDR: m_req=1 with the latched fields. Once asserted, m_req is never retracted before m_addr_ok, even on flush or reset-free events. On m_addr_ok go to DATA.
- DATA: m_req=0; wait for m_data_ok; capture m_rdata into the response register; go to RESP.
- RESP: assert the owner's *_data_ok for exactly one cycle with the captured data; go to IDLE.
- Priority: strict data-over-inst, evaluated only in IDLE. A grant is never pre-empted.
- Flush: if owner=inst and flush is high in ADDR or DATA, set cancel. The transaction completes on the port, but inst_data_ok is suppressed in RESP. In RESP, inst_data_ok = owner_inst & ~cancel & ~flush. Flush never affects a data-owned transaction, because stores past MEM are committed.
- m_data_ok outside DATA is ignored. m_addr_ok outside ADDR is ignored.
- Stall requests are combinational from requester req and response pulses.

## Timing
- Reset (synchronous): state=IDLE, owner=none, cancel=0, and all outputs 0 (m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata, inst/data_rdata, inst/data_data_ok). Reset mid-transaction abandons it; the memory side is reset together.
- Minimum latency with m_addr_ok and m_data_ok both immediate:
  - request seen in IDLE at cycle t;
  - m_req high at t+1;
  - DATA at t+2, m_data_ok at t+2;
  - *_data_ok pulse at t+3.
- Back-to-back: IDLE follows RESP, so the next grant occurs at t+4 and the minimum period is 4 cycles per access.
- Requester req may drop in the cycle after its data_ok pulse. A req still high in IDLE is a new request.
- Wait states: each cycle m_addr_ok or m_data_ok is late extends ADDR or DATA by one cycle. Port fields stay stable throughout ADDR.

## Test plan
- Single load: data_req with addr 0x1000, size 2; m_addr_ok at t+1; m_data_ok at t+3 with m_rdata 0xDEADBEEF -> data_data_ok pulse at t+4 with data_rdata 0xDEADBEEF, and stallreq_data high from t to t+3.
- Simultaneous requests: inst_req at 0xBFC00000 and data_req store 0x2000, wstrb 4'b0010, all held -> the store (m_wr=1) goes on the port first; the inst fetch starts in the IDLE after its RESP; each requester gets exactly one pulse.
- Flush during a fetch: inst granted; flush pulses in DATA; m_data_ok returns 0x12345678 -> no inst_data_ok, FSM returns to IDLE, and a new inst_req is then served normally.
- Flush during a data transaction: flush in ADDR of a store -> the store completes and data_data_ok still pulses.
- Address backpressure: m_addr_ok held low 5 cycles -> m_req and all fields are constant for 6 cycles; the transaction then completes normally.
- Reset mid-DATA: rst for 1 cycle -> all outputs 0 the next cycle, state IDLE; a late m_data_ok produces no pulse.
